map_rom_arbiter: RTL and testbench

Shares the single combinational map ROM between the ray tracer and the map overlay. The tracer normally has priority. During each horizontal blanking interval that precedes a new overlay map row, the block prefetches that full map row into a small row buffer. The overlay then reads the buffer during the visible area and never touches the ROM. If the prefetch falls behind the line deadline, it escalates to urgent priority and stalls the tracer.

---
 rtl/map_rom_arbiter.sv | 121 ++++++++++++
 tb/tb_map_rom_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/map_rom_arbiter.sv
// Map ROM arbiter: tracer has priority, overlay row prefetched into a small buffer during hblank.
// The prefetch escalates to urgent when the remaining cells would miss the end of the line.
module map_rom_arbiter #(
    parameter int unsigned MAP_WBITS = 4,
    parameter int unsigned MAP_HBITS = 4,
    parameter int unsigned MAP_SCALE = 3,
    parameter int unsigned H_VIEW    = 640,
    parameter int unsigned H_TOTAL   = 800,
    parameter int unsigned V_TOTAL   = 525
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [9:0]           hpos,
    input  logic [9:0]           vpos,
    input  logic                 i_tr_req,
    input  logic [MAP_WBITS-1:0] i_tr_col,
    input  logic [MAP_HBITS-1:0] i_tr_row,
    output logic                 o_tr_gnt,
    output logic [1:0]           o_tr_val,
    output logic [MAP_WBITS-1:0] o_map_col,
    output logic [MAP_HBITS-1:0] o_map_row,
    input  logic [1:0]           i_map_val,
    input  logic [MAP_WBITS-1:0] i_ov_col,
    input  logic [MAP_HBITS-1:0] i_ov_row,
    output logic [1:0]           o_ov_val,
    output logic                 o_fetching,
    output logic                 o_buf_valid
);

    localparam int unsigned    MapWidth = 1 << MAP_WBITS;
    localparam int unsigned    OvLines  = (1 << MAP_HBITS) << MAP_SCALE;
    localparam logic [MAP_WBITS:0] CntOne = 1;

    typedef enum logic [0:0] {StIdle, StFetch} state_e;

    state_e                 state_q, state_d;
    logic [MAP_WBITS:0]     cnt_q, cnt_d;
    logic [MAP_HBITS-1:0]   buf_row_q, buf_row_d;
    logic                   buf_valid_q, buf_valid_d;
    logic [1:0]             row_buf_q [MapWidth];
    logic [1:0]             row_buf_d [MapWidth];

    logic [9:0]             nxt;
    logic                   trigger;
    logic [MAP_HBITS-1:0]   tgt_row;
    logic [11:0]            left, remaining;
    logic                   urgent, fetch_owns, last;

    always_comb begin
        nxt       = (vpos == 10'(V_TOTAL - 1)) ? 10'd0 : vpos + 10'd1;
        trigger   = (hpos == 10'(H_VIEW)) && (nxt[MAP_SCALE-1:0] == '0) && (32'(nxt) < OvLines);
        tgt_row   = nxt[MAP_SCALE+MAP_HBITS-1:MAP_SCALE];
        left      = 12'(H_TOTAL) - 12'(hpos);
        remaining = 12'(MapWidth) - 12'(cnt_q);
        // Urgent once the cells still missing need every remaining pixel of the line.
        urgent     = (state_q == StFetch) && (left <= remaining);
        fetch_owns = (state_q == StFetch) && (!i_tr_req || urgent);
        last       = (cnt_q[MAP_WBITS-1:0] == MAP_WBITS'(MapWidth - 1));
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        buf_row_d   = buf_row_q;
        buf_valid_d = buf_valid_q;
        row_buf_d   = row_buf_q;
        unique case (state_q)
            StIdle: begin
                if (trigger) begin
                    state_d     = StFetch;
                    cnt_d       = '0;
                    buf_row_d   = tgt_row;
                    buf_valid_d = 1'b0;
                end
            end
            StFetch: begin
                if (fetch_owns) begin
                    row_buf_d[cnt_q[MAP_WBITS-1:0]] = i_map_val;
                    cnt_d = cnt_q + CntOne;
                    if (last) begin
                        buf_valid_d = 1'b1;
                        state_d     = StIdle;
                    end
                end
                // Line deadline: an unfinished row is abandoned at the hpos wrap.
                if (state_d == StFetch && hpos == 10'(H_TOTAL - 1)) begin
                    state_d     = StIdle;
                    buf_valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            buf_row_q   <= '0;
            buf_valid_q <= 1'b0;
            row_buf_q   <= '{default: 2'b00};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            buf_row_q   <= buf_row_d;
            buf_valid_q <= buf_valid_d;
            row_buf_q   <= row_buf_d;
        end
    end

    always_comb begin
        o_map_col   = fetch_owns ? cnt_q[MAP_WBITS-1:0] : i_tr_col;
        o_map_row   = fetch_owns ? buf_row_q : i_tr_row;
        o_tr_gnt    = i_tr_req && !urgent;
        o_tr_val    = i_map_val;
        o_fetching  = (state_q == StFetch);
        o_buf_valid = buf_valid_q;
        o_ov_val    = (buf_valid_q && i_ov_row == buf_row_q) ? row_buf_q[i_ov_col] : 2'b00;
    end

endmodule

// File: tb/tb_map_rom_arbiter.sv
// Directed bench for map_rom_arbiter: a rule-level model of the prefetch/arbitration is
// checked every cycle, plus literal expectations at the key beam positions.
module tb_map_rom_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] hpos = '0, vpos = '0;
    logic       i_tr_req = 1'b0;
    logic [3:0] i_tr_col = '0, i_tr_row = '0;
    logic       o_tr_gnt;
    logic [1:0] o_tr_val;
    logic [3:0] o_map_col, o_map_row;
    logic [1:0] i_map_val;
    logic [3:0] i_ov_col = '0, i_ov_row = '0;
    logic [1:0] o_ov_val;
    logic       o_fetching, o_buf_valid;

    int passed = 0;
    int total = 0;
    bit run_cmp = 1'b0;

    function automatic logic [1:0] rom(int r, int c);
        return 2'((r * 3 + c) % 4);
    endfunction

    assign i_map_val = rom(int'(o_map_row), int'(o_map_col));

    map_rom_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .hpos       (hpos),
        .vpos       (vpos),
        .i_tr_req   (i_tr_req),
        .i_tr_col   (i_tr_col),
        .i_tr_row   (i_tr_row),
        .o_tr_gnt   (o_tr_gnt),
        .o_tr_val   (o_tr_val),
        .o_map_col  (o_map_col),
        .o_map_row  (o_map_row),
        .i_map_val  (i_map_val),
        .i_ov_col   (i_ov_col),
        .i_ov_row   (i_ov_row),
        .o_ov_val   (o_ov_val),
        .o_fetching (o_fetching),
        .o_buf_valid(o_buf_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d want %0d (hpos=%0d vpos=%0d t=%0t)",
                      name, act, exp, hpos, vpos, $time);
    endtask

    // Model: fetching flag, number of cells filled, target row, valid flag and buffer contents.
    bit m_fetch, m_valid;
    int m_filled, m_row;
    int m_buf [16];
    int mh, mnxt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_fetch = 0; m_valid = 0; m_filled = 0; m_row = 0;
            for (int i = 0; i < 16; i++) m_buf[i] = 0;
        end else begin
            mh   = int'(hpos);
            mnxt = (int'(vpos) == 524) ? 0 : int'(vpos) + 1;
            if (!m_fetch) begin
                if (mh == 640 && mnxt % 8 == 0 && mnxt < 128) begin
                    m_fetch = 1; m_filled = 0; m_row = mnxt / 8; m_valid = 0;
                end
            end else begin
                if (!i_tr_req || (800 - mh) <= (16 - m_filled)) begin
                    m_buf[m_filled] = int'(rom(m_row, m_filled));
                    m_filled++;
                    if (m_filled == 16) begin m_fetch = 0; m_valid = 1; end
                end
                if (m_fetch && mh == 799) begin m_fetch = 0; m_valid = 0; end
            end
        end
    end

    bit e_urg, e_own, e_gnt;
    always @(negedge clk) begin
        if (run_cmp) begin
            e_urg = m_fetch && (800 - int'(hpos)) <= (16 - m_filled);
            e_own = m_fetch && (!i_tr_req || e_urg);
            e_gnt = i_tr_req && !e_urg;
            chk("fetching", int'(o_fetching), int'(m_fetch));
            chk("buf_valid", int'(o_buf_valid), int'(m_valid));
            chk("tr_gnt", int'(o_tr_gnt), int'(e_gnt));
            chk("map_col", int'(o_map_col), e_own ? m_filled : int'(i_tr_col));
            chk("map_row", int'(o_map_row), e_own ? m_row : int'(i_tr_row));
            if (e_gnt) chk("tr_val", int'(o_tr_val), int'(rom(int'(i_tr_row), int'(i_tr_col))));
            chk("ov_val", int'(o_ov_val),
                (m_valid && int'(i_ov_row) == m_row) ? m_buf[int'(i_ov_col)] : 0);
        end
    end

    // Inputs change just after the rising edge; returns just after the falling edge.
    task automatic step(int v, int h);
        @(posedge clk);
        #1;
        vpos = 10'(v);
        hpos = 10'(h);
        @(negedge clk);
        #1;
    endtask

    task automatic sweep(int v, int h0, int h1);
        for (int h = h0; h <= h1; h++) step(v, h);
    endtask

    int first_drop, drops, gnt_err;

    initial begin
        run_cmp = 1'b1;
        i_tr_req = 1'b1; i_tr_col = 4'd5; i_tr_row = 4'd6;
        step(0, 0);
        step(0, 1);
        chk("rst_gnt", int'(o_tr_gnt), 1);
        chk("rst_col", int'(o_map_col), 5);
        chk("rst_row", int'(o_map_row), 6);
        chk("rst_fetching", int'(o_fetching), 0);
        chk("rst_valid", int'(o_buf_valid), 0);
        chk("rst_ov", int'(o_ov_val), 0);
        reset = 1'b0;
        i_tr_req = 1'b0;

        // Uncontended fill of row 1.
        i_ov_col = 4'd3; i_ov_row = 4'd1;
        sweep(7, 630, 640);
        chk("s1_idle_at_640", int'(o_fetching), 0);
        step(7, 641);
        chk("s1_fetch_641", int'(o_fetching), 1);
        sweep(7, 642, 656);
        chk("s1_fetch_656", int'(o_fetching), 1);
        chk("s1_notvalid_656", int'(o_buf_valid), 0);
        step(7, 657);
        chk("s1_valid_657", int'(o_buf_valid), 1);
        chk("s1_idle_657", int'(o_fetching), 0);
        sweep(7, 658, 700);
        sweep(8, 0, 24);
        chk("s1_ov_r1c3", int'(o_ov_val), 2);
        i_ov_row = 4'd2;
        step(8, 25);
        chk("s1_ov_rowmiss", int'(o_ov_val), 0);

        // Tracer hogging the ROM; prefetch goes urgent near the end of the line.
        i_tr_req = 1'b1; i_tr_col = 4'd7; i_tr_row = 4'd9;
        i_ov_col = 4'd7; i_ov_row = 4'd2;
        first_drop = -1; drops = 0;
        for (int h = 600; h <= 799; h++) begin
            step(15, h);
            if (!o_tr_gnt) begin
                if (first_drop < 0) first_drop = h;
                drops++;
            end
        end
        chk("s2_first_drop", first_drop, 784);
        chk("s2_drops", drops, 16);
        step(16, 0);
        chk("s2_valid", int'(o_buf_valid), 1);
        chk("s2_ov_r2c7", int'(o_ov_val), 1);
        i_tr_req = 1'b0;

        // vpos wrap fetches row 0; row 15 is the last one in range.
        i_ov_row = 4'd0; i_ov_col = 4'd1;
        sweep(524, 636, 700);
        chk("s3_row0", int'(o_ov_val), 1);
        i_ov_row = 4'd15; i_ov_col = 4'd2;
        sweep(119, 636, 700);
        sweep(127, 636, 660);
        chk("s3_no_trig_127", int'(o_fetching), 0);
        step(128, 10);
        chk("s3_row15", int'(o_ov_val), 3);
        chk("s3_valid", int'(o_buf_valid), 1);

        // No row boundary: tracer keeps being granted whatever it asks.
        gnt_err = 0;
        for (int h = 630; h <= 700; h++) begin
            i_tr_req = 1'($urandom_range(0, 1));
            i_tr_col = 4'($urandom_range(0, 15));
            i_tr_row = 4'($urandom_range(0, 15));
            step(3, h);
            if (o_tr_gnt != i_tr_req || o_fetching) gnt_err++;
        end
        chk("s4_grants", gnt_err, 0);
        i_tr_req = 1'b0;

        // Reset during a fetch, then a clean refill.
        i_ov_row = 4'd4; i_ov_col = 4'd3;
        sweep(31, 636, 645);
        chk("s5_fetching", int'(o_fetching), 1);
        #2 reset = 1'b1;
        #1;
        chk("s5_rst_fetch", int'(o_fetching), 0);
        chk("s5_rst_valid", int'(o_buf_valid), 0);
        chk("s5_rst_ov", int'(o_ov_val), 0);
        @(negedge clk);
        #1 reset = 1'b0;
        sweep(31, 636, 700);
        chk("s5_refill_valid", int'(o_buf_valid), 1);
        chk("s5_ov_r4c3", int'(o_ov_val), 3);

        run_cmp = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
